// File: rtl/rf_wb_queue.sv
//------------------------------------------------------------------------------
// Module   : rf_wb_queue
// Brief    : In-order register-file writeback queue merging EXU and LSU results,
//            with combinational RAW hazard lookup against queued entries.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rf_wb_queue #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    exu_valid,
   input  logic [ADDR_WIDTH-1:0]   exu_addr,
   input  logic [DATA_WIDTH-1:0]   exu_data,
   output logic                    exu_ready,
   input  logic                    lsu_valid,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr,
   input  logic [DATA_WIDTH-1:0]   lsu_data,
   output logic                    lsu_ready,
   output logic                    rf_wen,
   output logic [ADDR_WIDTH-1:0]   rf_waddr,
   output logic [DATA_WIDTH-1:0]   rf_wdata,
   input  logic [ADDR_WIDTH-1:0]   chk_addr1,
   input  logic [ADDR_WIDTH-1:0]   chk_addr2,
   output logic                    hazard1,
   output logic                    hazard2,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam int                 c_CNT_W = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_CNT_W-1:0]    r_count;

   logic                  w_lsu_acc;
   logic                  w_exu_acc;
   logic [ADDR_WIDTH-1:0] w_push_addr;
   logic [DATA_WIDTH-1:0] w_push_data;
   logic                  w_push;
   logic                  w_pop;
   logic [DEPTH-1:0]      w_hit1;
   logic [DEPTH-1:0]      w_hit2;

   // LSU has fixed priority; at most one request is accepted per cycle.
   assign lsu_ready   = (r_count < c_DEPTH);
   assign exu_ready   = (r_count < c_DEPTH) && !lsu_valid;
   assign w_lsu_acc   = lsu_valid && lsu_ready;
   assign w_exu_acc   = exu_valid && exu_ready;
   assign w_push_addr = w_lsu_acc ? lsu_addr : exu_addr;
   assign w_push_data = w_lsu_acc ? lsu_data : exu_data;

   // Writes to x0 complete the handshake but are dropped.
   assign w_push = (w_lsu_acc || w_exu_acc) && (w_push_addr != '0);
   assign w_pop  = (r_count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + c_CNT_W'(1);
         else if (!w_push && w_pop) r_count <= r_count - c_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_addr[r_wr_ptr] <= w_push_addr;
         r_data[r_wr_ptr] <= w_push_data;
      end
   end

   assign rf_wen   = w_pop;
   assign rf_waddr = rf_wen ? r_addr[r_rd_ptr] : '0;
   assign rf_wdata = rf_wen ? r_data[r_rd_ptr] : '0;
   assign count    = r_count;

   // An entry is occupied when its distance from the head is below count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [c_PTR_W-1:0] w_ofs;
      logic               w_occ;
      assign w_ofs      = c_PTR_W'(gi) - r_rd_ptr;
      assign w_occ      = ({1'b0, w_ofs} < r_count);
      assign w_hit1[gi] = w_occ && (r_addr[gi] == chk_addr1);
      assign w_hit2[gi] = w_occ && (r_addr[gi] == chk_addr2);
   end

   assign hazard1 = (chk_addr1 != '0) && (|w_hit1);
   assign hazard2 = (chk_addr2 != '0) && (|w_hit2);

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
//------------------------------------------------------------------------------
// Module   : tb_rf_wb_queue
// Brief    : Randomised and directed bench for rf_wb_queue against a queue model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rf_wb_queue;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          exu_valid, lsu_valid;
   logic [AW-1:0] exu_addr, lsu_addr, chk_addr1, chk_addr2;
   logic [DW-1:0] exu_data, lsu_data;
   logic          exu_ready, lsu_ready, rf_wen, hazard1, hazard2;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;
   ent_t q[$];

   always #5 clk = ~clk;

   rf_wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .exu_valid (exu_valid),
      .exu_addr  (exu_addr),
      .exu_data  (exu_data),
      .exu_ready (exu_ready),
      .lsu_valid (lsu_valid),
      .lsu_addr  (lsu_addr),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .rf_wen    (rf_wen),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .hazard1   (hazard1),
      .hazard2   (hazard2),
      .count     (count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive inputs, compare outputs against the model, advance the model.
   task automatic step(input logic r,
                       input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic [AW-1:0] c1, input logic [AW-1:0] c2,
                       input bit do_chk);
      bit   room, h1, h2;
      ent_t e;
      @(negedge clk);
      rst = r; exu_valid = ev; exu_addr = ea; exu_data = ed;
      lsu_valid = lv; lsu_addr = la; lsu_data = ld;
      chk_addr1 = c1; chk_addr2 = c2;
      #1;
      room = (q.size() < DEPTH);
      h1 = 1'b0; h2 = 1'b0;
      foreach (q[i]) begin
         if (c1 != 0 && q[i].a == c1) h1 = 1'b1;
         if (c2 != 0 && q[i].a == c2) h2 = 1'b1;
      end
      if (do_chk) begin
         check("rf_wen",    64'(rf_wen),    64'(q.size() != 0));
         check("rf_waddr",  64'(rf_waddr),  q.size() != 0 ? 64'(q[0].a) : 64'd0);
         check("rf_wdata",  64'(rf_wdata),  q.size() != 0 ? 64'(q[0].d) : 64'd0);
         check("count",     64'(count),     64'(q.size()));
         check("lsu_ready", 64'(lsu_ready), 64'(room));
         check("exu_ready", 64'(exu_ready), 64'(room && !lv));
         check("hazard1",   64'(hazard1),   64'(h1));
         check("hazard2",   64'(hazard2),   64'(h2));
      end
      if (r) begin
         q.delete();
      end else begin
         if (q.size() != 0) void'(q.pop_front());
         if (room && (lv || ev)) begin
            e.a = lv ? la : ea;
            e.d = lv ? ld : ed;
            if (e.a != 0) q.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n, input logic [AW-1:0] c1);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, c1, 0, 1);
   endtask

   initial begin
      rst = 1'b1; exu_valid = 0; lsu_valid = 0; exu_addr = 0; lsu_addr = 0;
      exu_data = 0; lsu_data = 0; chk_addr1 = 0; chk_addr2 = 0;

      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Post-reset state, checked with constants as well as the model.
      @(negedge clk); #1;
      check("rst_wen",   64'(rf_wen),    64'd0);
      check("rst_count", 64'(count),     64'd0);
      check("rst_eready",64'(exu_ready), 64'd1);
      check("rst_lready",64'(lsu_ready), 64'd1);
      check("rst_haz",   64'({hazard1, hazard2}), 64'd0);
      @(posedge clk);

      // Single EXU push.
      step(0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 5'd3, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 5'd3, 0, 1);
      idle(1, 0);

      // Simultaneous requests: LSU first, EXU retried next cycle.
      step(0, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd5, 5'd6, 1);
      step(0, 1, 5'd5, 32'h55, 0, 0, 0, 5'd5, 5'd6, 1);
      idle(2, 5'd5);

      // Back-to-back fill while draining.
      for (int i = 1; i <= 4; i++) step(0, 1, 5'(i + 8), 32'(i), 0, 0, 0, 5'd9, 5'd12, 1);
      idle(2, 0);

      // Writes to x0 are dropped; no hazard for chk_addr 0.
      step(0, 1, 5'd0, 32'h1234, 0, 0, 0, 5'd0, 5'd0, 1);
      idle(2, 0);

      // Same destination twice.
      step(0, 1, 5'd7, 32'h1, 0, 0, 0, 5'd7, 0, 1);
      step(0, 0, 0, 0, 1, 5'd7, 32'h2, 5'd7, 0, 1);
      idle(3, 5'd7);

      // Reset mid-operation, then pointer wrap across 2*DEPTH pushes.
      step(0, 0, 0, 0, 1, 5'd7, 32'h3, 5'd7, 0, 1);
      step(1, 1, 5'd8, 32'h4, 0, 0, 0, 5'd7, 5'd8, 1);
      idle(2, 5'd7);
      for (int i = 0; i < 2 * DEPTH; i++)
         step(0, 1, 5'(i + 1), 32'(i * 3 + 1), 0, 0, 0, 5'(i + 1), 5'(i), 1);
      idle(2, 0);

      // Randomised traffic.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom % 60) == 0,
              1'($urandom % 2), 5'($urandom % 8), $urandom,
              ($urandom % 3) == 0, 5'($urandom % 8), $urandom,
              5'($urandom % 8), 5'($urandom % 8), 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
